// File: rtl/aes_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the AES key schedule.
package aes_pkg;

  localparam logic [1:0] ALG_128 = 2'b00;
  localparam logic [1:0] ALG_192 = 2'b01;
  localparam logic [1:0] ALG_256 = 2'b10;
  localparam logic [1:0] ALG_ILL = 2'b11;

  localparam int MAX_WORDS = 60;

  localparam logic [3:0] NK_128 = 4'd4,  NK_192 = 4'd6,  NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10, NR_192 = 4'd12, NR_256 = 4'd14;
  localparam logic [3:0] STEPS_128 = 4'd10, STEPS_192 = 4'd8, STEPS_256 = 4'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] alg);
    case (alg)
      ALG_192: return NK_192;
      ALG_256: return NK_256;
      default: return NK_128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] alg);
    case (alg)
      ALG_192: return NR_192;
      ALG_256: return NR_256;
      default: return NR_128;
    endcase
  endfunction

  function automatic logic [3:0] steps_of(input logic [1:0] alg);
    case (alg)
      ALG_192: return STEPS_192;
      ALG_256: return STEPS_256;
      default: return STEPS_128;
    endcase
  endfunction

  function automatic logic [5:0] word_total(input logic [1:0] alg);
    return {nr_of(alg), 2'b00} + 6'd4;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, p;
    x = a;
    y = b;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Inverse as a^254 by square-and-multiply, then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, inv;
    p   = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_schedule_expander.sv
// One combinational key-expansion step: produces the next Nk words from the current window.
module Key_Expansion_new
  import aes_pkg::*;
(
  input  logic [255:0] window,
  input  logic [1:0]   algorithm,
  input  logic [3:0]   i_Nk,
  output logic [255:0] next_window
);

  logic [31:0] prev [8];
  logic [31:0] nxt  [8];
  logic [31:0] last;
  logic [31:0] temp;
  logic [7:0]  rcon;
  logic [3:0]  nk;

  // i_Nk carries the step number; Rcon for step s is x^(s-1).
  always_comb begin
    nk = nk_of(algorithm);
    for (int k = 0; k < 8; k++) prev[k] = window[255 - 32*k -: 32];
    case (algorithm)
      ALG_192: last = prev[5];
      ALG_256: last = prev[7];
      default: last = prev[3];
    endcase
    rcon = 8'h01;
    for (int i = 1; i < 15; i++)
      if (i < int'(i_Nk)) rcon = xtime(rcon);
    temp   = sub_word({last[23:0], last[31:24]}) ^ {rcon, 24'h000000};
    nxt[0] = prev[0] ^ temp;
    for (int k = 1; k < 8; k++) begin
      temp   = (algorithm == ALG_256 && k == 4) ? sub_word(nxt[k-1]) : nxt[k-1];
      nxt[k] = (k < int'(nk)) ? (prev[k] ^ temp) : 32'h0;
    end
    next_window = '0;
    for (int k = 0; k < 8; k++) next_window[255 - 32*k -: 32] = nxt[k];
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key schedule: iterates the expander once per clock and serves round keys by index.
module aes_key_schedule #(
  parameter int MAX_WORDS = aes_pkg::MAX_WORDS,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       algorithm,
  input  logic [255:0]     key_in,
  output logic             busy,
  output logic             keys_ready,
  output logic             err_alg,
  input  logic             rk_rd_en,
  input  logic [IDX_W-1:0] rk_idx,
  output logic [127:0]     rk_out,
  output logic             rk_valid
);
  import aes_pkg::*;

  state_t        state;
  logic [1:0]    alg_reg;
  logic [3:0]    step;
  logic [255:0]  window;
  logic [255:0]  next_window;
  logic [255:0]  masked_key;
  logic [31:0]   key_buf [MAX_WORDS];
  logic [5:0]    wr_addr [8];
  logic [7:0]    wr_en;
  logic [3:0]    nk_cur;
  logic [5:0]    rd_base;
  logic          load;

  Key_Expansion_new u_step (
    .window      (window),
    .algorithm   (alg_reg),
    .i_Nk        (step),
    .next_window (next_window)
  );

  assign load    = (state != ST_EXPAND) && start && (algorithm != ALG_ILL);
  assign nk_cur  = nk_of(alg_reg);
  assign rd_base = {rk_idx, 2'b00};

  always_comb begin
    case (algorithm)
      ALG_128: masked_key = {key_in[255:128], 128'h0};
      ALG_192: masked_key = {key_in[255:64], 64'h0};
      default: masked_key = key_in;
    endcase
  end

  // Writes past the schedule length are dropped on the final 192/256 steps.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      wr_addr[k] = ({2'b00, nk_cur} * {2'b00, step}) + 6'(k);
      wr_en[k]   = (state == ST_EXPAND) && (k < int'(nk_cur)) &&
                   (wr_addr[k] < word_total(alg_reg));
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 8; k++)
        if (k < int'(nk_of(algorithm))) key_buf[k] <= masked_key[255 - 32*k -: 32];
    end
    for (int k = 0; k < 8; k++)
      if (wr_en[k]) key_buf[wr_addr[k]] <= next_window[255 - 32*k -: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      alg_reg    <= ALG_128;
      step       <= 4'd0;
      window     <= '0;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
      err_alg    <= 1'b0;
      rk_out     <= '0;
      rk_valid   <= 1'b0;
    end else begin
      err_alg <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && algorithm == ALG_ILL) begin
            err_alg    <= 1'b1;
            keys_ready <= 1'b0;
            state      <= ST_IDLE;
          end else if (start) begin
            alg_reg    <= algorithm;
            window     <= masked_key;
            step       <= 4'd1;
            keys_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          window <= next_window;
          step   <= step + 4'd1;
          if (step == steps_of(alg_reg)) begin
            state      <= ST_DONE;
            keys_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Reads see the pre-edge keys_ready/alg_reg, so a concurrent start returns the old schedule.
      if (rk_rd_en) begin
        if (keys_ready && rk_idx <= nr_of(alg_reg)) begin
          rk_valid <= 1'b1;
          rk_out   <= {key_buf[rd_base], key_buf[rd_base + 6'd1],
                       key_buf[rd_base + 6'd2], key_buf[rd_base + 6'd3]};
        end else begin
          rk_valid <= 1'b0;
          rk_out   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a word-by-word AES key expansion model.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   algorithm;
  logic [255:0] key_in;
  logic         busy;
  logic         keys_ready;
  logic         err_alg;
  logic         rk_rd_en;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] w_model [60];
  int          nr_model;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .algorithm  (algorithm),
    .key_in     (key_in),
    .busy       (busy),
    .keys_ready (keys_ready),
    .err_alg    (err_alg),
    .rk_rd_en   (rk_rd_en),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from log/antilog tables over generator 0x03, then the affine map.
  task automatic build_sbox();
    int         lg [256];
    logic [7:0] ex [256];
    logic [7:0] x, inv;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] alg, input logic [255:0] key);
    int nk, total;
    logic [31:0] t;
    logic [7:0]  rc;
    nk       = 4 + 2 * int'(alg);
    nr_model = nk + 6;
    total    = 4 * (nr_model + 1);
    rc       = 8'h01;
    for (int i = 0; i < nk; i++) w_model[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w_model[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w_model[i] = w_model[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int i);
    return {w_model[4*i], w_model[4*i+1], w_model[4*i+2], w_model[4*i+3]};
  endfunction

  task automatic do_start(input logic [1:0] alg, input logic [255:0] key);
    @(negedge clk);
    start = 1'b1;
    algorithm = alg;
    key_in = key;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the number of edges after the start edge until keys_ready was set.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (!keys_ready && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic read_key(input int idx, output logic [127:0] k, output logic v);
    @(negedge clk);
    rk_rd_en = 1'b1;
    rk_idx = 4'(idx);
    @(posedge clk);
    #1;
    rk_rd_en = 1'b0;
    k = rk_out;
    v = rk_valid;
  endtask

  task automatic test_reset();
    logic [127:0] k;
    logic v;
    rst_n = 1'b0; start = 1'b0; algorithm = 2'b00; key_in = '0; rk_rd_en = 1'b0; rk_idx = '0;
    #12;
    checks++;
    if ({busy, keys_ready, err_alg, rk_valid} !== 4'b0000 || rk_out !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got flags %b rk_out %h expected 0000 and 0",
               {busy, keys_ready, err_alg, rk_valid}, rk_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read_key(0, k, v);
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_before_expand: got rk_valid %b expected 0", v);
    end
  endtask

  task automatic test_known_vectors();
    int e;
    logic [127:0] k;
    logic v;
    do_start(2'b00, KEY128 | 256'($urandom));
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b expected 1", busy);
    end
    wait_ready(e);
    checks++;
    if (e + 1 !== 11) begin
      errors++;
      $display("[TB] FAIL latency_128: got %0d expected 11", e + 1);
    end
    read_key(1, k, v);
    checks++;
    if (k !== 128'ha0fafe1788542cb123a339392a6c7605 || v !== 1'b1) begin
      errors++;
      $display("[TB] FAIL aes128_rk1: got %h/%b expected a0fafe1788542cb123a339392a6c7605/1", k, v);
    end
    read_key(10, k, v);
    checks++;
    if (k !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("[TB] FAIL aes128_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", k);
    end
    read_key(0, k, v);
    checks++;
    if (k !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++;
      $display("[TB] FAIL aes128_rk0: got %h expected 2b7e151628aed2a6abf7158809cf4f3c", k);
    end

    do_start(2'b01, KEY192 | 256'($urandom));
    wait_ready(e);
    checks++;
    if (e + 1 !== 9) begin
      errors++;
      $display("[TB] FAIL latency_192: got %0d expected 9", e + 1);
    end
    read_key(12, k, v);
    checks++;
    if (k !== 128'he98ba06f448c773c8ecc720401002202) begin
      errors++;
      $display("[TB] FAIL aes192_rk12: got %h expected e98ba06f448c773c8ecc720401002202", k);
    end
    read_key(13, k, v);
    checks++;
    if (v !== 1'b0 || k !== 128'h0) begin
      errors++;
      $display("[TB] FAIL aes192_rk13_illegal: got %h/%b expected 0/0", k, v);
    end

    do_start(2'b10, KEY256);
    wait_ready(e);
    checks++;
    if (e + 1 !== 8) begin
      errors++;
      $display("[TB] FAIL latency_256: got %0d expected 8", e + 1);
    end
    read_key(14, k, v);
    checks++;
    if (k !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      errors++;
      $display("[TB] FAIL aes256_rk14: got %h expected fe4890d1e6188d0b046df344706c631e", k);
    end
  endtask

  task automatic test_illegal();
    logic [127:0] k;
    logic v;
    do_start(2'b11, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    checks++;
    if ({err_alg, busy, keys_ready} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL illegal_pulse: got err/busy/ready %b expected 100", {err_alg, busy, keys_ready});
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_alg !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_one_cycle: got err_alg %b expected 0", err_alg);
    end
    read_key(2, k, v);
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_after_illegal: got rk_valid %b expected 0", v);
    end
  endtask

  task automatic test_ignored_restart();
    int e;
    logic [127:0] k;
    logic v;
    logic [255:0] key_a;
    key_a = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    model_expand(2'b00, key_a);
    do_start(2'b00, key_a);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    do_start(2'b11, ~key_a);
    checks++;
    if (err_alg !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_illegal_start: got err/busy %b%b expected 01", err_alg, busy);
    end
    do_start(2'b10, ~key_a);
    wait_ready(e);
    checks++;
    if (e + 6 !== 11) begin
      errors++;
      $display("[TB] FAIL latency_with_ignored_start: got %0d expected 11", e + 6);
    end
    for (int i = 0; i <= 10; i++) begin
      read_key(i, k, v);
      checks++;
      if (k !== model_rk(i) || v !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ignored_restart_rk%0d: got %h/%b expected %h/1", i, k, v, model_rk(i));
      end
    end
  endtask

  task automatic test_restart_done();
    int e;
    logic [127:0] k, old_rk;
    logic v;
    old_rk = model_rk(5);
    @(negedge clk);
    start = 1'b1; algorithm = 2'b10; key_in = KEY256;
    rk_rd_en = 1'b1; rk_idx = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0; rk_rd_en = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_out !== old_rk) begin
      errors++;
      $display("[TB] FAIL read_with_restart: got %h/%b expected %h/1", rk_out, rk_valid, old_rk);
    end
    checks++;
    if (keys_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_drops_ready: got ready/busy %b%b expected 01", keys_ready, busy);
    end
    model_expand(2'b10, KEY256);
    wait_ready(e);
    checks++;
    if (e + 1 !== 8) begin
      errors++;
      $display("[TB] FAIL restart_latency: got %0d expected 8", e + 1);
    end
    for (int i = 0; i <= 14; i += 7) begin
      read_key(i, k, v);
      checks++;
      if (k !== model_rk(i) || v !== 1'b1) begin
        errors++;
        $display("[TB] FAIL restart_rk%0d: got %h/%b expected %h/1", i, k, v, model_rk(i));
      end
    end
  endtask

  task automatic test_async_reset();
    int e;
    logic [127:0] k;
    logic v;
    do_start(2'b01, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0});
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, keys_ready, rk_valid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL async_reset: got busy/ready/valid %b expected 000", {busy, keys_ready, rk_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(2'b01, KEY192);
    wait_ready(e);
    read_key(12, k, v);
    checks++;
    if (k !== 128'he98ba06f448c773c8ecc720401002202 || v !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_rk12: got %h/%b expected e98ba06f448c773c8ecc720401002202/1", k, v);
    end
  endtask

  task automatic test_random();
    int e, idx, exp_lat;
    logic [1:0] alg;
    logic [255:0] key, used;
    logic [127:0] k, exp_k;
    logic v, exp_v;
    for (int n = 0; n < 8; n++) begin
      alg = 2'($urandom_range(0, 2));
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      used = (alg == 2'b00) ? {key[255:128], 128'h0} :
             (alg == 2'b01) ? {key[255:64], 64'h0} : key;
      model_expand(alg, used);
      exp_lat = (alg == 2'b00) ? 11 : (alg == 2'b01) ? 9 : 8;
      do_start(alg, key);
      wait_ready(e);
      checks++;
      if (e + 1 !== exp_lat) begin
        errors++;
        $display("[TB] FAIL random_latency: got %0d expected %0d", e + 1, exp_lat);
      end
      for (int r = 0; r < 4; r++) begin
        idx = (r == 3) ? $urandom_range(nr_model + 1, 15) : $urandom_range(0, nr_model);
        read_key(idx, k, v);
        exp_v = (idx <= nr_model);
        exp_k = exp_v ? model_rk(idx) : 128'h0;
        checks++;
        if (k !== exp_k || v !== exp_v) begin
          errors++;
          $display("[TB] FAIL random_rk alg%0d idx%0d: got %h/%b expected %h/%b", alg, idx, k, v, exp_k, exp_v);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    build_sbox();
    test_reset();
    test_known_vectors();
    test_illegal();
    test_ignored_restart();
    test_restart_done();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
